// File: rtl/mem_burst_pkg.sv
// rtl/mem_burst_pkg.sv - shared widths and state encoding for the burst master
package mem_burst_pkg;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        DRAIN  = 3'd3,
        VERIFY = 3'd4
    } state_t;
endpackage

// File: rtl/burst_addr_gen.sv
// rtl/burst_addr_gen.sv - burst address/beat counter with wrap and last flag (READBACK_CHECK_EN adds o_beat)
module burst_addr_gen
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
`ifdef READBACK_CHECK_EN
    ,
    output logic [LEN_W-1:0]  o_beat
`endif
);
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W:0]    r_cnt;
    logic [LEN_W-1:0]  r_len;

    // Address wraps naturally at 2^ADDR_W; load wins over step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_addr <= i_start_addr;
            r_cnt  <= '0;
            r_len  <= i_len;
        end else if (i_step) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == {1'b0, r_len});
`ifdef READBACK_CHECK_EN
    assign o_beat = r_cnt[LEN_W-1:0];
`endif
endmodule

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst initiator for the ren/wen memory port pair (READBACK_CHECK_EN adds write readback verify)
module mem_burst_master
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
`ifdef READBACK_CHECK_EN
    ,
    output logic              chk_err,
    output logic              chk_done
`endif
);
    state_t            r_state;
    state_t            w_next;
    logic              r_rd_pend;
    logic              w_accept;
    logic              w_wr_beat;
    logic              w_load;
    logic              w_step;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_load_addr;
    logic [LEN_W-1:0]  w_load_len;
    logic              w_last;

    assign w_accept  = cmd_valid & cmd_ready;
    assign w_wr_beat = wr_valid & wr_ready;
    assign w_step    = w_wr_beat | mem_ren;

`ifdef READBACK_CHECK_EN
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [LEN_W-1:0]  r_cmd_len;
    logic [DATA_W-1:0] r_copy [2**LEN_W];
    logic [LEN_W-1:0]  w_beat;
    logic [LEN_W-1:0]  r_beat_d;
    logic              r_vfy_d;
    logic              r_chk_err;
    logic              w_mismatch;

    // Reload the generator with the same range for the internal re-read.
    assign w_load      = w_accept | (w_wr_beat & w_last);
    assign w_load_addr = (r_state == IDLE) ? cmd_addr : r_cmd_addr;
    assign w_load_len  = (r_state == IDLE) ? cmd_len  : r_cmd_len;
    assign w_mismatch  = r_rd_pend & r_vfy_d & (mem_dout != r_copy[r_beat_d]);
    assign chk_err     = r_chk_err | w_mismatch;
    assign chk_done    = (r_state == DRAIN) & r_vfy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_beat_d   <= '0;
            r_vfy_d    <= 1'b0;
            r_chk_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd_addr <= cmd_addr;
                r_cmd_len  <= cmd_len;
            end
            if (w_wr_beat) r_copy[w_beat] <= wr_data;
            r_beat_d  <= w_beat;
            r_vfy_d   <= (r_state == VERIFY);
            r_chk_err <= chk_err;
        end
    end
`else
    assign w_load      = w_accept;
    assign w_load_addr = cmd_addr;
    assign w_load_len  = cmd_len;
`endif

    burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_start_addr (w_load_addr),
        .i_len        (w_load_len),
        .i_step       (w_step),
        .o_addr       (w_addr),
        .o_last       (w_last)
`ifdef READBACK_CHECK_EN
        ,
        .o_beat       (w_beat)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rd_pend <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_pend <= mem_ren;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (w_accept) w_next = cmd_write ? WRITE : READ;
`ifdef READBACK_CHECK_EN
            WRITE:  if (w_wr_beat && w_last) w_next = VERIFY;
            VERIFY: if (w_last) w_next = DRAIN;
`else
            WRITE:  if (w_wr_beat && w_last) w_next = IDLE;
`endif
            READ:   if (w_last) w_next = DRAIN;
            DRAIN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Verify re-reads keep rd_valid low so the client never sees them.
    always_comb begin
        cmd_ready = (r_state == IDLE) & ~rst;
        wr_ready  = (r_state == WRITE);
        busy      = (r_state != IDLE);
        mem_ren   = (r_state == READ) | (r_state == VERIFY);
        mem_wen   = wr_valid & (r_state == WRITE);
        mem_waddr = mem_wen ? w_addr : '0;
        mem_din   = mem_wen ? wr_data : '0;
        mem_raddr = mem_ren ? w_addr : '0;
`ifdef READBACK_CHECK_EN
        rd_valid  = r_rd_pend & ~r_vfy_d;
`else
        rd_valid  = r_rd_pend;
`endif
        rd_data   = rd_valid ? mem_dout : '0;
    end
endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - self-checking bench: vector table, hand corner cases, random bursts vs reference memory
module tb_mem_burst_master;
    import mem_burst_pkg::*;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int MEM_N = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy, mem_ren, mem_wen;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
`ifdef READBACK_CHECK_EN
    logic          chk_err, chk_done;
`endif

    always #5 clk = ~clk;

    mem_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef READBACK_CHECK_EN
        , .chk_err(chk_err), .chk_done(chk_done)
`endif
    );

    logic [DW-1:0] mem [MEM_N];
    logic [DW-1:0] ref_mem [MEM_N];
    bit            flip_en = 1'b0;
    int            flip_addr = 0;

    // Memory with registered 1-cycle read; optional single-bit corruption on one address.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_din;
        if (mem_ren) mem_dout <= mem[mem_raddr] ^ ((flip_en && int'(mem_raddr) == flip_addr) ? 8'h04 : 8'h00);
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int obs_wa[$], obs_wd[$], obs_ra[$], obs_ren_cyc[$], obs_rd[$], obs_rd_cyc[$];
    int excl_viol = 0, hold_viol = 0, done_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_wen) begin obs_wa.push_back(int'(mem_waddr)); obs_wd.push_back(int'(mem_din)); end
            if (mem_ren) begin obs_ra.push_back(int'(mem_raddr)); obs_ren_cyc.push_back(cyc); end
            if (rd_valid) begin obs_rd.push_back(int'(rd_data)); obs_rd_cyc.push_back(cyc); end
            if (mem_wen && mem_ren) excl_viol++;
            if (cmd_ready && busy) hold_viol++;
`ifdef READBACK_CHECK_EN
            if (chk_done) done_cnt++;
`endif
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stall: 0 none, 1 two idle cycles before beat 1, 2 random gaps
    task automatic run_burst(input bit w, input int addr, input int len, input int base,
                             input int stall, input bit rnd, output int n_seen, output int last_addr);
        logic [DW-1:0] d [16];
        int n, k, to, stall_left;
        bit hs, v, stalled;
        n = len + 1;
        for (int i = 0; i < 16; i++) d[i] = rnd ? DW'($urandom) : DW'(base + i);
        obs_wa.delete(); obs_wd.delete(); obs_ra.delete();
        obs_ren_cyc.delete(); obs_rd.delete(); obs_rd_cyc.delete();
        done_cnt = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = AW'(addr); cmd_len = LW'(len);
        tick();
        cmd_valid = 1'b0;
        if (w) begin
            k = 0; to = 0; stall_left = 0; stalled = 1'b0;
            while (k < n && to < 200) begin
                if (stall == 1 && k == 1 && !stalled) begin stall_left = 2; stalled = 1'b1; end
                if (stall_left > 0) begin v = 1'b0; stall_left--; end
                else if (stall == 2) v = ($urandom_range(0, 3) != 0);
                else v = 1'b1;
                wr_valid = v;
                wr_data = v ? d[k] : DW'($urandom);
                #1;
                hs = wr_valid && wr_ready;
                tick();
                if (hs) k++;
                to++;
            end
            wr_valid = 1'b0;
            check("write_beats_accepted", k, n);
        end
        to = 0;
        while (!cmd_ready && to < 100) begin tick(); to++; end
        check("return_to_idle", int'(cmd_ready), 1);
        if (w) begin
            n_seen = obs_wa.size();
            check("wen_count", n_seen, n);
            for (int i = 0; i < n && i < obs_wa.size(); i++) begin
                check("waddr", obs_wa[i], (addr + i) % MEM_N);
                check("wdata", obs_wd[i], int'(d[i]));
            end
            for (int i = 0; i < n; i++) ref_mem[(addr + i) % MEM_N] = d[i];
            last_addr = (n_seen > 0) ? obs_wa[n_seen-1] : -1;
            check("no_rd_valid_on_write", obs_rd.size(), 0);
`ifdef READBACK_CHECK_EN
            check("chk_done_pulses", done_cnt, 1);
`endif
        end else begin
            n_seen = obs_ra.size();
            check("ren_count", n_seen, n);
            check("rd_valid_count", obs_rd.size(), n);
            for (int i = 0; i < n && i < obs_ra.size() && i < obs_rd.size(); i++) begin
                check("raddr", obs_ra[i], (addr + i) % MEM_N);
                check("rdata", obs_rd[i], int'(ref_mem[(addr + i) % MEM_N]));
                check("rd_lag", obs_rd_cyc[i] - obs_ren_cyc[i], 1);
            end
            last_addr = (n_seen > 0) ? obs_ra[n_seen-1] : -1;
        end
    endtask

    typedef struct {
        bit w;
        int addr;
        int len;
        int base;
        int stall;
        int exp_beats;
        int exp_last;
    } vec_t;

    vec_t vecs[8];
    int n_seen, last_addr;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_N; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        vecs[0] = '{1'b1, 'h010, 3,  'hA0, 0, 4,  'h013};
        vecs[1] = '{1'b0, 'h010, 3,  0,    0, 4,  'h013};
        vecs[2] = '{1'b1, 'h7FC, 15, 'h30, 0, 16, 'h00B};
        vecs[3] = '{1'b0, 'h7FC, 15, 0,    0, 16, 'h00B};
        vecs[4] = '{1'b1, 'h200, 2,  'h5C, 1, 3,  'h202};
        vecs[5] = '{1'b0, 'h200, 2,  0,    0, 3,  'h202};
        vecs[6] = '{1'b1, 'h7FF, 0,  'hE7, 0, 1,  'h7FF};
        vecs[7] = '{1'b0, 'h7FF, 0,  0,    0, 1,  'h7FF};

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_mem_ren", int'(mem_ren), 0);
        check("rst_mem_wen", int'(mem_wen), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_addrs", int'(mem_raddr) | int'(mem_waddr) | int'(mem_din) | int'(rd_data), 0);
        rst = 1'b0;
        tick();
        check("cmd_ready_after_reset", int'(cmd_ready), 1);

        for (int v = 0; v < 8; v++) begin
            run_burst(vecs[v].w, vecs[v].addr, vecs[v].len, vecs[v].base, vecs[v].stall, 1'b0,
                      n_seen, last_addr);
            check("vec_beats", n_seen, vecs[v].exp_beats);
            check("vec_last_addr", last_addr, vecs[v].exp_last);
        end
        check("first_read_data", int'(ref_mem['h010]), 'hA0);

        // Reset during the second beat of an 8-beat read.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'('h010); cmd_len = LW'(7);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("midread_ren_before_rst", int'(mem_ren), 1);
        rst = 1'b1;
        tick();
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_mem_ren", int'(mem_ren), 0);
        check("rstmid_rd_valid", int'(rd_valid), 0);
        check("rstmid_outs", int'(mem_raddr) | int'(rd_data) | int'(mem_wen) | int'(wr_ready), 0);
        rst = 1'b0;
        tick();
        check("rstmid_cmd_ready", int'(cmd_ready), 1);
        check("rstmid_no_pending", int'(rd_valid), 0);

        for (int r = 0; r < 24; r++) begin
            int a, l;
            a = $urandom_range(0, MEM_N - 1);
            l = $urandom_range(0, 15);
            run_burst(r[0] ? 1'b0 : 1'b1, a, l, 0, 2, 1'b1, n_seen, last_addr);
            if (!r[0]) run_burst(1'b0, a, l, 0, 0, 1'b0, n_seen, last_addr);
        end

`ifdef READBACK_CHECK_EN
        check("chk_err_clean", int'(chk_err), 0);
        flip_en = 1'b1; flip_addr = 'h102;
        run_burst(1'b1, 'h100, 3, 'h11, 0, 1'b0, n_seen, last_addr);
        flip_en = 1'b0;
        check("chk_err_flip", int'(chk_err), 1);
        run_burst(1'b1, 'h300, 1, 'h22, 0, 1'b0, n_seen, last_addr);
        check("chk_err_sticky", int'(chk_err), 1);
`endif

        check("ren_wen_exclusive", excl_viol, 0);
        check("cmd_ready_only_idle", hold_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
